// File: rtl/i2c_target_responder_if.sv
// Bus bundle for i2c_target_responder: raw SCL/SDA pins plus the register-bank write/read port.
interface i2c_target_responder_if;
  logic       i2c_serial_clock;
  logic       i2c_serial_data_input;
  logic       i2c_serial_data_drive_low;
  logic [7:0] reg_address;
  logic       reg_write;
  logic [7:0] reg_write_data;
  logic [7:0] reg_read_data;
  logic       busy;

  modport slave (
    input  i2c_serial_clock, i2c_serial_data_input, reg_read_data,
    output i2c_serial_data_drive_low, reg_address, reg_write, reg_write_data, busy
  );

  modport master (
    output i2c_serial_clock, i2c_serial_data_input, reg_read_data,
    input  i2c_serial_data_drive_low, reg_address, reg_write, reg_write_data, busy
  );
endinterface

// File: rtl/i2c_target_responder.sv
// I2C target: decodes START/STOP/address/pointer/data from oversampled SCL/SDA into register-write strobes.
// Optional read support is enabled by defining I2C_TARGET_READ_EN.
module i2c_target_responder #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h39
) (
  input logic              clock,
  input logic              reset_n,
  i2c_target_responder_if.slave bus
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] PTR       = 4'd3;
  localparam logic [3:0] PTR_ACK   = 4'd4;
  localparam logic [3:0] WDATA     = 4'd5;
  localparam logic [3:0] WDATA_ACK = 4'd6;
`ifdef I2C_TARGET_READ_EN
  localparam logic [3:0] RDATA     = 4'd7;
  localparam logic [3:0] RDATA_ACK = 4'd8;
`endif
  localparam logic [3:0] WAIT      = 4'd9;

  logic [3:0] state;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic [7:0] shift;
  logic [3:0] bit_cnt;
  logic       drive_low, busy, reg_write;
  logic [7:0] reg_address, reg_write_data;
`ifdef I2C_TARGET_READ_EN
  logic       rw, rd_ack;
`endif

  logic scl_s, sda_s, scl_rise, scl_fall, start, stop;
  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & ~sda_s & sda_d;
  assign stop     = scl_s & scl_d & sda_s & ~sda_d;

  assign bus.i2c_serial_data_drive_low = drive_low;
  assign bus.reg_address               = reg_address;
  assign bus.reg_write                 = reg_write;
  assign bus.reg_write_data            = reg_write_data;
  assign bus.busy                      = busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      scl_sync       <= 2'b11;
      sda_sync       <= 2'b11;
      scl_d          <= 1'b1;
      sda_d          <= 1'b1;
      shift          <= 8'h00;
      bit_cnt        <= 4'd0;
      drive_low      <= 1'b0;
      busy           <= 1'b0;
      reg_write      <= 1'b0;
      reg_address    <= 8'h00;
      reg_write_data <= 8'h00;
`ifdef I2C_TARGET_READ_EN
      rw             <= 1'b0;
      rd_ack         <= 1'b0;
`endif
    end else begin
      scl_sync  <= {scl_sync[0], bus.i2c_serial_clock};
      sda_sync  <= {sda_sync[0], bus.i2c_serial_data_input};
      scl_d     <= scl_s;
      sda_d     <= sda_s;
      reg_write <= 1'b0;
      // Auto-increment lands the cycle after the write strobe
      if (reg_write) reg_address <= reg_address + 8'd1;

      if (start) begin
        bit_cnt   <= 4'd0;
        drive_low <= 1'b0;
        state     <= ADDR;
      end else if (stop) begin
        bit_cnt   <= 4'd0;
        drive_low <= 1'b0;
        busy      <= 1'b0;
        state     <= IDLE;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise && !bit_cnt[3]) begin
              shift   <= {shift[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt[3]) begin
              bit_cnt <= 4'd0;
              case (state)
                ADDR: begin
                  if (shift[7:1] != SLAVE_ADDRESS) begin
                    state <= WAIT;
`ifdef I2C_TARGET_READ_EN
                  end else begin
                    rw        <= shift[0];
                    drive_low <= 1'b1;
                    busy      <= 1'b1;
                    state     <= ADDR_ACK;
                  end
`else
                  end else if (shift[0]) begin
                    state <= WAIT;
                  end else begin
                    drive_low <= 1'b1;
                    busy      <= 1'b1;
                    state     <= ADDR_ACK;
                  end
`endif
                end
                PTR: begin
                  reg_address <= shift;
                  drive_low   <= 1'b1;
                  state       <= PTR_ACK;
                end
                default: begin
                  reg_write_data <= shift;
                  reg_write      <= 1'b1;
                  drive_low      <= 1'b1;
                  state          <= WDATA_ACK;
                end
              endcase
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              drive_low <= 1'b0;
              state     <= PTR;
`ifdef I2C_TARGET_READ_EN
              if (rw) begin
                shift     <= bus.reg_read_data;
                drive_low <= ~bus.reg_read_data[7];
                state     <= RDATA;
              end
`endif
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              drive_low <= 1'b0;
              state     <= WDATA;
            end
          end
`ifdef I2C_TARGET_READ_EN
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt[3]) begin
                drive_low <= 1'b0;
                bit_cnt   <= 4'd0;
                rd_ack    <= 1'b0;
                state     <= RDATA_ACK;
              end else begin
                shift     <= {shift[6:0], 1'b0};
                drive_low <= ~shift[6];
              end
            end
          end
          RDATA_ACK: begin
            // Pointer bumps at the ACK rise so the bank has settled by the following fall
            if (scl_rise) begin
              if (!sda_s) begin
                rd_ack      <= 1'b1;
                reg_address <= reg_address + 8'd1;
              end else begin
                busy  <= 1'b0;
                state <= WAIT;
              end
            end else if (scl_fall && rd_ack) begin
              shift     <= bus.reg_read_data;
              drive_low <= ~bus.reg_read_data[7];
              bit_cnt   <= 4'd0;
              state     <= RDATA;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
